// File: rtl/button_pkg.sv
// button_pkg: decoder FSM state encoding, default timing constants and the terminal-count helper
package button_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
  localparam logic [31:0] DEBOUNCE_DEFAULT = 32'd50_000;
  localparam logic [31:0] LONG_HOLD_DEFAULT = 32'd100_000_000;
  function automatic logic [31:0] last_count(input logic [31:0] n);
    return (n <= 32'd1) ? 32'd0 : n - 32'd1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus debounce counter; clock, reset (sync, active-low), raw_n (raw active-low button) -> level (debounced, 1 = released)
module btn_debounce
  import button_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level
);
  localparam logic [31:0] LAST = last_count(DEBOUNCE);
  logic [1:0] sync;
  logic [31:0] cnt;
  logic differ, flip;
  always_comb begin
    differ = sync[1] != level;
    flip = differ && cnt >= LAST;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      sync <= 2'b11;
      level <= 1'b1;
      cnt <= '0;
    end else begin
      sync <= {sync[0], raw_n};
      cnt <= (!differ || flip) ? 32'd0 : cnt + 32'd1;
      level <= flip ? sync[1] : level;
    end
endmodule

// File: rtl/button_decoder.sv
// button_decoder: debounced button with short/long press pulses and long-press mode toggle; clock, reset (sync, active-low), btn_n -> pressed, short_press, long_press, mode
module button_decoder
  import button_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter logic [31:0] LONG_HOLD = LONG_HOLD_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic mode
);
  localparam logic [31:0] HOLD_LAST = last_count(LONG_HOLD);
  state_t state, state_n;
  logic [31:0] hold;
  logic level;
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clock(clock),
    .reset(reset),
    .raw_n(btn_n),
    .level(level)
  );
  always_comb begin
    short_press = state == PRESS && !pressed;
    long_press = state == PRESS && pressed && hold >= HOLD_LAST;
    state_n = state == IDLE ? (pressed ? PRESS : IDLE) :
              state == PRESS ? (short_press ? IDLE : long_press ? HELD : PRESS) :
              (pressed ? HELD : IDLE);
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      pressed <= 1'b0;
      hold <= '0;
      mode <= 1'b0;
    end else begin
      state <= state_n;
      pressed <= !level;
      hold <= state == IDLE ? 32'd0 : (state == PRESS && hold != '1) ? hold + 32'd1 : hold;
      mode <= mode ^ long_press;
    end
endmodule
